mem_responder: RTL and testbench



---
 rtl/mem_responder_if.sv | 30 +++
 rtl/mem_responder.sv | 140 ++++++++++++++
 tb/tb_mem_responder.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response bus between the CPU control FSM and the
// data-memory responder.
//   req   - access request (master -> slave)
//   we    - 1 = write, 0 = read, sampled with req
//   addr  - 16-bit word address, sampled with req
//   wdata - write data, sampled with req
//   ack   - one-cycle completion pulse (slave -> master)
//   rdata - read data / write echo, valid while ack=1
//   err   - out-of-range access, valid while ack=1
//   busy  - responder is not idle
interface mem_responder_if;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        ack;
    logic [15:0] rdata;
    logic        err;
    logic        busy;

    modport master (
        output req, we, addr, wdata,
        input  ack, rdata, err, busy
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, rdata, err, busy
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: single-port 2^ADDR_W x 16-bit data memory serving word reads
// and writes over a req/ack handshake. Each access is stretched by
// WAIT_CYCLES wait states (0..15). Addresses with any bit set above ADDR_W
// complete with err=1 and rdata=0 and never touch the array.
//   clk    - system clock, rising edge
//   resetn - asynchronous active-low reset (control state and outputs only)
//   bus    - slave side of mem_responder_if (req/we/addr/wdata in,
//            ack/rdata/err/busy out)
module mem_responder #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic          clk,
    input  logic          resetn,
    mem_responder_if.slave bus
);

    localparam int unsigned DEPTH   = 1 << ADDR_W;
    localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [3:0]  wcnt;

    logic        cap_we;
    logic [15:0] cap_addr;
    logic [15:0] cap_wdata;

    logic [15:0] rdata_q;
    logic        err_q;

    logic [15:0] mem [DEPTH];

    logic        acc_we;
    logic [15:0] acc_addr;
    logic [15:0] acc_wdata;
    logic        acc_oor;
    logic        enter_resp;
    logic        mem_wr;

    // With no wait states the access executes on the capture edge itself, so
    // the operands come straight from the bus; otherwise from the capture regs.
    always_comb begin
        acc_we    = cap_we;
        acc_addr  = cap_addr;
        acc_wdata = cap_wdata;
        if (state == IDLE) begin
            acc_we    = bus.we;
            acc_addr  = bus.addr;
            acc_wdata = bus.wdata;
        end
        acc_oor    = (acc_addr >> ADDR_W) != 16'h0000;
        enter_resp = (next_state == RESP) && (state != RESP);
        mem_wr     = enter_resp && acc_we && !acc_oor;
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.req) begin
                    next_state = (WAIT_CYCLES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (wcnt == 4'd1) begin
                    next_state = RESP;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.ack   = (state == RESP);
        bus.busy  = (state != IDLE);
        bus.rdata = rdata_q;
        bus.err   = err_q;
    end

    // Capture, wait counter and response registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wcnt      <= '0;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            if (state == IDLE && bus.req) begin
                cap_we    <= bus.we;
                cap_addr  <= bus.addr;
                cap_wdata <= bus.wdata;
                wcnt      <= WAIT_LD;
            end else if (state == WAIT) begin
                wcnt <= wcnt - 4'd1;
            end

            if (enter_resp) begin
                if (acc_oor) begin
                    err_q   <= 1'b1;
                    rdata_q <= '0;
                end else if (acc_we) begin
                    rdata_q <= acc_wdata;
                end else begin
                    rdata_q <= mem[acc_addr[ADDR_W-1:0]];
                end
            end else if (state == RESP) begin
                err_q <= 1'b0;
            end
        end
    end

    // Array: no reset, contents persist across resetn
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[acc_addr[ADDR_W-1:0]] <= acc_wdata;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: three responders (WAIT_CYCLES 2, 0, 1; ADDR_W 8) driven
// by directed transactions, checked every cycle against a transaction-level
// model plus hand-computed literal expectations.
module tb_mem_responder;

    localparam int WCS [3] = '{2, 0, 1};

    logic clk;
    logic resetn;

    logic [2:0]  req;
    logic [2:0]  we;
    logic [15:0] addr  [3];
    logic [15:0] wdata [3];
    logic [2:0]  ack;
    logic [2:0]  err;
    logic [2:0]  busy;
    logic [15:0] rdata [3];

    int n_checks = 0;
    int n_err    = 0;
    bit cmp_on   = 0;

    mem_responder_if if0 ();
    mem_responder_if if1 ();
    mem_responder_if if2 ();

    mem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) u0 (.clk(clk), .resetn(resetn), .bus(if0));
    mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) u1 (.clk(clk), .resetn(resetn), .bus(if1));
    mem_responder #(.ADDR_W(8), .WAIT_CYCLES(1)) u2 (.clk(clk), .resetn(resetn), .bus(if2));

    assign if0.req = req[0];  assign if0.we = we[0];  assign if0.addr = addr[0];  assign if0.wdata = wdata[0];
    assign if1.req = req[1];  assign if1.we = we[1];  assign if1.addr = addr[1];  assign if1.wdata = wdata[1];
    assign if2.req = req[2];  assign if2.we = we[2];  assign if2.addr = addr[2];  assign if2.wdata = wdata[2];

    assign ack[0] = if0.ack;  assign err[0] = if0.err;  assign busy[0] = if0.busy;  assign rdata[0] = if0.rdata;
    assign ack[1] = if1.ack;  assign err[1] = if1.err;  assign busy[1] = if1.busy;  assign rdata[1] = if1.rdata;
    assign ack[2] = if2.ack;  assign err[2] = if2.err;  assign busy[2] = if2.busy;  assign rdata[2] = if2.rdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // Each accepted request completes at absolute edge (capture + WAIT_CYCLES);
    // ack/err are visible for the one cycle after that edge.
    bit [15:0] mm [3][256];
    bit        mv [3][256];
    bit        inflight [3];
    bit        in_resp  [3];
    int        done_at  [3];
    bit        c_we     [3];
    bit [15:0] c_addr   [3];
    bit [15:0] c_wd     [3];
    bit        e_ack    [3];
    bit        e_err    [3];
    bit        e_busy   [3];
    bit [15:0] e_rdata  [3];
    bit        e_rk     [3];
    int        cyc = 0;

    initial begin
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) begin
                for (int i = 0; i < 3; i++) begin
                    inflight[i] = 0; in_resp[i] = 0;
                    e_ack[i] = 0; e_err[i] = 0; e_busy[i] = 0;
                    e_rdata[i] = 16'h0000; e_rk[i] = 1;
                end
            end else begin
                cyc++;
                for (int i = 0; i < 3; i++) begin
                    if (in_resp[i]) begin
                        in_resp[i] = 0; e_ack[i] = 0; e_err[i] = 0; e_busy[i] = 0;
                    end else if (!inflight[i] && req[i]) begin
                        inflight[i] = 1; e_busy[i] = 1;
                        c_we[i] = we[i]; c_addr[i] = addr[i]; c_wd[i] = wdata[i];
                        done_at[i] = cyc + WCS[i];
                    end
                    if (inflight[i] && cyc == done_at[i]) begin
                        inflight[i] = 0; in_resp[i] = 1; e_ack[i] = 1; e_rk[i] = 1;
                        if (c_addr[i] > 16'h00FF) begin
                            e_err[i] = 1; e_rdata[i] = 16'h0000;
                        end else if (c_we[i]) begin
                            mm[i][c_addr[i][7:0]] = c_wd[i];
                            mv[i][c_addr[i][7:0]] = 1;
                            e_rdata[i] = c_wd[i];
                        end else begin
                            e_rdata[i] = mm[i][c_addr[i][7:0]];
                            e_rk[i]    = mv[i][c_addr[i][7:0]];
                        end
                    end
                end
            end
        end
    end

    // Per-cycle compare against the model
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_on && resetn) begin
                for (int i = 0; i < 3; i++) begin
                    chk($sformatf("ack%0d", i),  {31'd0, ack[i]},  {31'd0, e_ack[i]});
                    chk($sformatf("busy%0d", i), {31'd0, busy[i]}, {31'd0, e_busy[i]});
                    chk($sformatf("err%0d", i),  {31'd0, err[i]},  {31'd0, e_err[i]});
                    if (e_rk[i])
                        chk($sformatf("rdata%0d", i), {16'd0, rdata[i]}, {16'd0, e_rdata[i]});
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    // Called just after a negedge. Returns the number of negedges from driving
    // req until ack is seen, then idles one more cycle so the next request is
    // seen in IDLE.
    task automatic xact(input int i, input logic w, input logic [15:0] a, input logic [15:0] d,
                        output logic [15:0] rd, output logic e, output int lat);
        req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d;
        rd = '0; e = 1'b0;
        @(negedge clk);
        req[i] = 1'b0;
        lat = 1;
        while (!ack[i] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk($sformatf("ack_seen%0d", i), {31'd0, ack[i]}, 32'd1);
        rd = rdata[i];
        e  = err[i];
        @(negedge clk);
    endtask

    logic [15:0] rd;
    logic        e;
    int          lat;
    logic [2:0]  ackv;
    logic [2:0]  busyv;
    logic [15:0] r0;
    logic [15:0] r2;
    int          nack;
    int          consec;
    int          pos [3];
    logic        prev;

    initial begin
        resetn = 1'b0;
        req = '0; we = '0;
        for (int i = 0; i < 3; i++) begin addr[i] = '0; wdata[i] = '0; end
        repeat (3) @(negedge clk);
        #2 resetn = 1'b1;
        @(negedge clk);
        cmp_on = 1;

        // Reset values on every instance
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_ack%0d", i),   {31'd0, ack[i]},  32'd0);
            chk($sformatf("rst_busy%0d", i),  {31'd0, busy[i]}, 32'd0);
            chk($sformatf("rst_err%0d", i),   {31'd0, err[i]},  32'd0);
            chk($sformatf("rst_rdata%0d", i), {16'd0, rdata[i]}, 32'h0);
        end

        // WAIT_CYCLES=2: write BEEF to 0x0010, then read it back
        xact(0, 1'b1, 16'h0010, 16'hBEEF, rd, e, lat);
        chk("wr_lat", lat, 32'd3);
        chk("wr_echo", {16'd0, rd}, 32'hBEEF);
        chk("wr_err", {31'd0, e}, 32'd0);
        xact(0, 1'b0, 16'h0010, 16'h0000, rd, e, lat);
        chk("rd_0010", {16'd0, rd}, 32'hBEEF);
        chk("rd_lat", lat, 32'd3);

        // Boundary: top in-range address, out-of-range read and write, no aliasing
        xact(0, 1'b1, 16'h00FF, 16'h7E57, rd, e, lat);
        xact(0, 1'b1, 16'h0000, 16'hC0DE, rd, e, lat);
        xact(0, 1'b0, 16'h0100, 16'h0000, rd, e, lat);
        chk("oor_rd_err", {31'd0, e}, 32'd1);
        chk("oor_rd_data", {16'd0, rd}, 32'h0);
        xact(0, 1'b1, 16'h0100, 16'hFFFF, rd, e, lat);
        chk("oor_wr_err", {31'd0, e}, 32'd1);
        xact(0, 1'b1, 16'h8000, 16'hFFFF, rd, e, lat);
        chk("oor_msb_err", {31'd0, e}, 32'd1);
        xact(0, 1'b0, 16'h0000, 16'h0000, rd, e, lat);
        chk("no_alias", {16'd0, rd}, 32'hC0DE);
        chk("no_alias_err", {31'd0, e}, 32'd0);
        xact(0, 1'b0, 16'h00FF, 16'h0000, rd, e, lat);
        chk("rd_00ff", {16'd0, rd}, 32'h7E57);

        // Input changes after capture are ignored
        xact(0, 1'b1, 16'h0006, 16'h6666, rd, e, lat);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 16'h0005; wdata[0] = 16'h1234;
        @(negedge clk);
        req[0] = 1'b0; addr[0] = 16'h0006; wdata[0] = 16'hFFFF;
        lat = 1;
        while (!ack[0] && lat < 40) begin @(negedge clk); lat++; end
        chk("chg_echo", {16'd0, rdata[0]}, 32'h1234);
        @(negedge clk);
        xact(0, 1'b0, 16'h0005, 16'h0000, rd, e, lat);
        chk("chg_rd05", {16'd0, rd}, 32'h1234);
        xact(0, 1'b0, 16'h0006, 16'h0000, rd, e, lat);
        chk("chg_rd06", {16'd0, rd}, 32'h6666);

        // Reset during WAIT discards the pending write
        xact(0, 1'b1, 16'h0007, 16'h5555, rd, e, lat);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 16'h0007; wdata[0] = 16'hAAAA;
        @(negedge clk);
        req[0] = 1'b0;
        chk("pre_rst_busy", {31'd0, busy[0]}, 32'd1);
        #2 resetn = 1'b0;
        #1;
        chk("arst_ack",   {31'd0, ack[0]},  32'd0);
        chk("arst_busy",  {31'd0, busy[0]}, 32'd0);
        chk("arst_err",   {31'd0, err[0]},  32'd0);
        chk("arst_rdata", {16'd0, rdata[0]}, 32'h0);
        @(negedge clk);
        #2 resetn = 1'b1;
        nack = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (ack[0]) nack++;
        end
        chk("rst_no_ack", nack, 32'd0);
        xact(0, 1'b0, 16'h0007, 16'h0000, rd, e, lat);
        chk("rst_rd07", {16'd0, rd}, 32'h5555);

        // WAIT_CYCLES=0: back-to-back reads with req held high
        xact(1, 1'b1, 16'h0001, 16'h1111, rd, e, lat);
        chk("wc0_lat", lat, 32'd1);
        xact(1, 1'b1, 16'h0002, 16'h2222, rd, e, lat);
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 16'h0001;
        @(negedge clk);
        ackv[0] = ack[1]; busyv[0] = busy[1]; r0 = rdata[1];
        addr[1] = 16'h0002;
        @(negedge clk);
        ackv[1] = ack[1]; busyv[1] = busy[1];
        @(negedge clk);
        ackv[2] = ack[1]; busyv[2] = busy[1]; r2 = rdata[1];
        req[1] = 1'b0;
        @(negedge clk);
        chk("b2b_ack",  {29'd0, ackv},  32'b101);
        chk("b2b_busy", {29'd0, busyv}, 32'b101);
        chk("b2b_rd1",  {16'd0, r0}, 32'h1111);
        chk("b2b_rd2",  {16'd0, r2}, 32'h2222);

        // WAIT_CYCLES=1: three accesses with req held high
        xact(2, 1'b1, 16'h0003, 16'h3333, rd, e, lat);
        chk("wc1_lat", lat, 32'd2);
        req[2] = 1'b1; we[2] = 1'b0; addr[2] = 16'h0003;
        nack = 0; consec = 0; prev = 1'b0;
        for (int k = 0; k < 3; k++) pos[k] = -1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (ack[2]) begin
                if (prev) consec++;
                if (nack < 3) pos[nack] = k;
                nack++;
                if (nack == 3) req[2] = 1'b0;
            end
            prev = ack[2];
        end
        req[2] = 1'b0;
        chk("hold_nack", nack, 32'd3);
        chk("hold_consec", consec, 32'd0);
        chk("hold_pos0", pos[0], 32'd2);
        chk("hold_pos1", pos[1], 32'd5);
        chk("hold_pos2", pos[2], 32'd8);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
